// File: rtl/ahbl_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
package ahbl_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int SLOT_MSB = 27;
  localparam int SLOT_LSB = 24;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
  function automatic logic trans_active(input logic [1:0] htrans);
    logic active;
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      default:                   active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/ahbl_apb_timeout.sv
// ACCESS-phase watchdog: counts PREADY-low ACCESS cycles and flags the cycle
// in which the limit is reached.
module ahbl_apb_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // Fires during the stalled cycle that brings the count up to the limit.
  assign expired = count_en && (count_reg == LIMIT);

endmodule

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge, one transfer outstanding, 16 slots.
// Optional ACCESS timeout enabled by defining AHBL_APB_BRIDGE_TIMEOUT_EN.
module ahbl_apb_bridge
  import ahbl_apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 24,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETN,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [31:0]               HWDATA,
  input  logic                      HREADY,
  output logic [31:0]               HRDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [15:0]               PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [31:0]               PWDATA,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  state_e                    state_reg, state_next;
  logic [3:0]                slot_reg;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg;
  logic                      pwrite_reg;
  logic [31:0]               pwdata_reg;
  logic [31:0]               hrdata_reg;
  logic                      psel_on;
  logic                      accept;
  logic                      read_done;
  logic                      timeout_hit;

  // Every APB access is a full word, so HSIZE and the upper address bits are not needed.
  logic unused_inputs;
  assign unused_inputs = ^{HSIZE, HADDR};

  assign accept    = (state_reg == ST_IDLE) && HSEL && HREADY && trans_active(HTRANS);
  assign read_done = (state_reg == ST_ACCESS) && PREADY && !PSLVERR && !pwrite_reg && !timeout_hit;

`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
  ahbl_apb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (HCLK),
    .rst_n   (HRESETN),
    .clear   (state_reg == ST_SETUP),
    .count_en((state_reg == ST_ACCESS) && !PREADY),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      slot_reg   <= '0;
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
      hrdata_reg <= '0;
    end else begin
      if (accept) begin
        slot_reg   <= HADDR[SLOT_MSB:SLOT_LSB];
        paddr_reg  <= HADDR[APB_ADDR_WIDTH-1:0];
        pwrite_reg <= HWRITE;
      end
      if (state_reg == ST_WDATA) begin
        pwdata_reg <= HWDATA;
      end
      if (read_done) begin
        hrdata_reg <= PRDATA;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    psel_on    = 1'b0;
    PENABLE    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = HWRITE ? ST_WDATA : ST_SETUP;
        end
      end
      ST_WDATA: begin
        HREADYOUT  = 1'b0;
        state_next = ST_SETUP;
      end
      ST_SETUP: begin
        HREADYOUT  = 1'b0;
        psel_on    = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        HREADYOUT = 1'b0;
        psel_on   = 1'b1;
        PENABLE   = 1'b1;
        if (timeout_hit) begin
          state_next = ST_ERR1;
        end else if (PREADY) begin
          state_next = PSLVERR ? ST_ERR1 : ST_IDLE;
        end
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP      = HRESP_ERROR;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_psel
      assign PSEL[gi] = psel_on && (slot_reg == 4'(gi));
    end
  endgenerate

  assign PADDR  = paddr_reg;
  assign PWRITE = pwrite_reg;
  assign PWDATA = pwdata_reg;
  assign HRDATA = hrdata_reg;

endmodule
